// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - valid/ready command to APB requester bridge with optional access timeout (APB_TIMEOUT_EN)
module apb_master_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              sel,
    output logic              enable,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] out_data,
    input  logic              ready
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t state;
    logic   done;
    logic   accept;
    logic   timeout_hit;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Abort on the stalled cycle that would take the count to TIMEOUT_CYCLES.
    assign timeout_hit = (state == S_ACCESS) && !ready &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    assign done      = (state == S_ACCESS) && ready;
    assign cmd_ready = rstn && ((state == S_IDLE) || done);
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = sel;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            sel       <= 1'b0;
            enable    <= 1'b0;
            wr        <= 1'b0;
            addr      <= '0;
            wr_data   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
`endif
        end else begin
            rsp_valid <= done || timeout_hit;
`ifdef APB_TIMEOUT_EN
            rsp_err   <= timeout_hit;
`endif
            if (done && !wr)
                rsp_rdata <= out_data;

            if (accept) begin
                wr      <= cmd_wr;
                addr    <= cmd_addr;
                wr_data <= cmd_wdata;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state  <= S_SETUP;
                        sel    <= 1'b1;
                        enable <= 1'b0;
                    end
                end
                S_SETUP: begin
                    state  <= S_ACCESS;
                    enable <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                S_ACCESS: begin
                    if (done) begin
                        // A pending command chains straight into SETUP with sel held.
                        if (accept) begin
                            state  <= S_SETUP;
                            enable <= 1'b0;
                        end else begin
                            state  <= S_IDLE;
                            sel    <= 1'b0;
                            enable <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        state  <= S_IDLE;
                        sel    <= 1'b0;
                        enable <= 1'b0;
                    end
`ifdef APB_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state  <= S_IDLE;
                    sel    <= 1'b0;
                    enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - randomized bench for apb_master_bridge against a transaction-age reference model
module tb_apb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_wr = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;
    logic          sel;
    logic          enable;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] out_data = '0;
    logic          ready = 1'b0;

    apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .sel(sel), .enable(enable), .wr(wr), .addr(addr),
        .wr_data(wr_data), .out_data(out_data), .ready(ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a transfer is tracked by its age in cycles since acceptance.
    bit          m_active;
    int          m_age;
    int          m_stalls;
    bit          m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    bit          m_rsp_valid;
    bit          m_rsp_err;
    logic [DW-1:0] m_rsp_rdata;
    bit          m_timeout_en;

    task automatic model_reset();
        m_active = 0; m_age = 0; m_stalls = 0;
        m_wr = 0; m_addr = '0; m_wdata = '0;
        m_rsp_valid = 0; m_rsp_err = 0; m_rsp_rdata = '0;
    endtask

    function automatic bit exp_cmd_ready(input bit rst_n_in, input bit rdy);
        return rst_n_in && (!m_active || (m_age >= 1 && rdy));
    endfunction

    task automatic step(input bit rst_n_in, input bit v, input bit w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit rdy, input logic [DW-1:0] od);
        bit er, finish, abort, acc;
        @(negedge clk);
        rstn = rst_n_in; cmd_valid = v; cmd_wr = w; cmd_addr = a;
        cmd_wdata = d; ready = rdy; out_data = od;
        if (!rst_n_in) model_reset();
        #1;
        er = exp_cmd_ready(rst_n_in, rdy);
        check("cmd_ready", cmd_ready, er);
        check("sel", sel, m_active);
        check("enable", enable, m_active && m_age >= 1);
        check("busy", busy, m_active);
        check("wr", wr, m_wr);
        check("addr", addr, m_addr);
        check("wr_data", wr_data, m_wdata);
        check("rsp_valid", rsp_valid, m_rsp_valid);
        check("rsp_err", rsp_err, m_rsp_err);
        check("rsp_rdata", rsp_rdata, m_rsp_rdata);
        @(posedge clk);
        if (rst_n_in) begin
            finish = m_active && m_age >= 1 && rdy;
            abort  = m_timeout_en && m_active && m_age >= 1 && !rdy && (m_stalls == TO - 1);
            acc    = v && er;
            m_rsp_valid = finish || abort;
            m_rsp_err   = abort;
            if (finish && !m_wr) m_rsp_rdata = od;
            if (acc) begin
                m_wr = w; m_addr = a; m_wdata = d;
                m_active = 1; m_age = 0; m_stalls = 0;
            end else if (finish || abort) begin
                m_active = 0;
            end else if (m_active) begin
                if (m_age >= 1 && !rdy) m_stalls++;
                m_age++;
            end
        end
    endtask

    int pulses;

    initial begin
`ifdef APB_TIMEOUT_EN
        m_timeout_en = 1;
`else
        m_timeout_en = 0;
`endif
        model_reset();

        // reset state
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 5, 5, 1, 0);

        // single write, ready tied high
        step(1, 1, 1, 22, 12, 1, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        #1 check("t1_addr_setup", addr, 64'd22);
        step(1, 0, 0, 0, 0, 1, 0);
        #1 check("t1_rsp_pulse", rsp_valid, 1'b1);
        step(1, 0, 0, 0, 0, 1, 0);

        // read with three wait states
        step(1, 1, 0, 30, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 12);
        #1 check("t2_rdata", rsp_rdata, 64'd12);
        step(1, 0, 0, 0, 0, 1, 0);

        // back-to-back writes with cmd_valid held
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            int idx;
            idx = (k + 1) / 2;
            step(1, idx <= 3, 1, 23 + idx, 13 + idx, 1, 0);
            #1 if (rsp_valid) pulses++;
        end
        check("t3_pulses", pulses, 4);

        // reset mid-access, then a normal read
        step(1, 1, 0, 40, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(1, 1, 0, 41, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 99);
        #1 check("t4_rdata", rsp_rdata, 64'd99);
        step(1, 0, 0, 0, 0, 1, 0);

`ifdef APB_TIMEOUT_EN
        // timeout abort with ready held low
        step(1, 1, 0, 50, 0, 0, 7);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 0, 0, 0, 7);
            #1 if (rsp_valid && rsp_err) pulses++;
        end
        check("t5_err_pulses", pulses, 1);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit rb;
            rb = ($urandom_range(0, 199) != 0);
            step(rb, $urandom_range(0, 99) < 60, $urandom_range(0, 1),
                 $urandom, $urandom, $urandom_range(0, 99) < 65, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
